perf_window_timer: RTL and testbench
====================================

// Module: perf_window_timer
// PURPOSE
//  Parametrised timebase for the bandwidth monitors: free-running cycle timestamp plus a cascade
//  of NUM_STAGE decade-style trigger pulses (period BASE_DIV*RATIO^k cycles). Adds pause/clear
//  control, a selectable measurement window with running window id, and timestamp snapshots.
//  One instance per clock domain under test; monitors consume trig/win_end/ts.
// PARAMETERS
//  TS_W       48  timestamp width (cycles)
//  NUM_STAGE  9   number of trigger stages
//  BASE_DIV   10  cycles per stage-0 period (>=1)
//  RATIO      10  period multiplier between adjacent stages (>=2)
//  ID_W       16  window id width
// PORTS
//  clk_1000m  in   1                  single clock; all logic on posedge
//  perf_rst   in   1                  synchronous, active-high reset
//  en         in   1                  1: timebase advances; 0: hold
//  clr        in   1                  sync clear of timebase/window state (reset does the rest)
//  win_sel    in   $clog2(NUM_STAGE)  stage index defining the window length
//  snap_req   in   1                  capture ts
//  ts         out  TS_W               elapsed advancing cycles
//  ts_wrap    out  1                  sticky: ts has wrapped since reset/clr
//  trig       out  NUM_STAGE          one-cycle stage pulses
//  win_end    out  1                  one-cycle pulse: current window closes
//  win_id     out  ID_W               id of current window
//  snap_ts    out  TS_W               captured ts
//  snap_vld   out  1                  one-cycle: snap_ts updated
// BEHAVIOUR
//  - Reset: every output 0, prescalers 0, sel_q 0. Synchronous only; perf_rst beats clr/en.
//  - advance = en & ~clr. On advance ts<=ts+1 (mod 2^TS_W); 2^TS_W-1 -> 0 sets ts_wrap.
//  - PERIOD_k = BASE_DIV*RATIO^k. Prescaler cascade: stage0 mod-BASE_DIV, stage k mod-RATIO,
//    carries in same cycle. trig[k] registered: high exactly in cycles where ts has just advanced
//    to a nonzero multiple of PERIOD_k (counting from reset/clr). No pulse while en=0.
//  - trig[k] implies trig[j] for all j<k in the same cycle.
//  - Cadence counts advances, not ts value: continues uninterrupted across ts wrap.
//  - clr: ts, ts_wrap, prescalers, trig, win_end, win_id -> 0; sel_q <= win_sel. Takes effect
//    next cycle; snap_ts/snap_vld unaffected.
//  - Window: sel_q = min(win_sel, NUM_STAGE-1), loaded at clr and in every win_end cycle, so a
//    win_sel change applies to the next window only. win_end = trig[sel_q] (same cycle).
//    win_id holds the closing window's id during win_end, increments after it, wraps 2^ID_W-1->0.
//  - Snapshot: snap_req in cycle t -> snap_ts = ts visible in cycle t, snap_vld=1 in t+1 only.
//    snap_ts holds until next request. snap_req with clr captures the pre-clear ts.
//  - Elaboration error if BASE_DIV<1, RATIO<2, or PERIOD_{NUM_STAGE-1} >= 2^63.
// STRUCTURE
//  perf_timer_pkg: default parameter constants; function period(k,base,ratio) -> longint;
//    function sel_clamp(). Shared with bandwidth monitors.
//  Sub-module perf_prescale_stage (mod-N counter, inc/clr in, carry out), generated
//    NUM_STAGE times: stage0 N=BASE_DIV with inc=advance, stage k N=RATIO with inc=carry[k-1].
//  Top: ts counter, trig regs, window/sel_q/win_id logic, snapshot regs.
// TESTING
//  1 Defaults, en=1 after reset: first trig[0] at ts=10, trig[1] at ts=100, trig[2] at ts=1000;
//    each exactly 1 cycle wide; trig[0]&trig[1] coincide at ts=100.
//  2 BASE_DIV=2,RATIO=3,NUM_STAGE=3: en low for 4 cycles at ts=5 -> ts holds 5, no trig; resume
//    -> trig[0] at 6, trig[1] at 6, trig[2] at 18.
//  3 win_sel=1 (defaults): win_end at ts=100,200; win_id 0->1->2. Set win_sel=0 at ts=150 ->
//    next win_end still at ts=200, then at 210, 220.
//  4 clr at ts=57 with en=1: next cycle ts=0, win_id=0, trig=0; trig[0] next at ts=10.
//  5 TS_W=8: run 300 advances -> ts wraps, ts_wrap=1 at ts=0; trig[0] cadence unbroken
//    (every 10 advances, e.g. at ts=4 after wrap). snap_req at ts=77 -> snap_ts=77, snap_vld
//    one cycle later; snap_req+clr at ts=30 -> snap_ts=30.
//  6 perf_rst asserted mid-window with en=1 -> all outputs 0 next cycle; win_sel=15 with
//    NUM_STAGE=9 clamps to stage 8.

Source files
------------

// File: rtl/perf_timer_pkg.sv
`default_nettype none
// ============================================================================
// perf_timer_pkg : shared constants and helpers for the perf timebase
// Rev 1.0
// ============================================================================
package perf_timer_pkg;

   localparam int unsigned c_TS_W      = 48;
   localparam int unsigned c_NUM_STAGE = 9;
   localparam int unsigned c_BASE_DIV  = 10;
   localparam int unsigned c_RATIO     = 10;
   localparam int unsigned c_ID_W      = 16;

   // Period of stage k in cycles; -1 flags a period that does not fit in 63 bits.
   function automatic longint period(input int unsigned k,
                                     input int unsigned base,
                                     input int unsigned ratio);
      longint p;
      p = longint'(base);
      for (int unsigned i = 0; i < k; i++) begin
         if (ratio == 0) return -1;
         if (p > (64'sh7FFF_FFFF_FFFF_FFFF / longint'(ratio))) return -1;
         p = p * longint'(ratio);
      end
      return p;
   endfunction

   function automatic int unsigned sel_clamp(input int unsigned sel,
                                             input int unsigned num_stage);
      return (sel >= num_stage) ? (num_stage - 1) : sel;
   endfunction

   function automatic int unsigned sel_width(input int unsigned num_stage);
      return (num_stage > 1) ? $clog2(num_stage) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/perf_prescale_stage.sv
`default_nettype none
// ============================================================================
// perf_prescale_stage : mod-N prescaler, carry asserted on the wrapping increment
// Rev 1.0
// ============================================================================
module perf_prescale_stage #(
   parameter int unsigned N = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_carry
);

   localparam int unsigned        c_CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(N - 1);
   localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

   logic [c_CNT_W-1:0] r_cnt;
   logic               w_at_last;

   assign w_at_last = (r_cnt == c_LAST);
   assign o_carry   = i_inc & w_at_last;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= w_at_last ? '0 : (r_cnt + c_ONE);
      end
   end

endmodule
`default_nettype wire

// File: rtl/perf_window_timer.sv
`default_nettype none
// ============================================================================
// perf_window_timer : cycle timestamp, decade trigger cascade, windows, snapshots
// Rev 1.0
// ============================================================================
module perf_window_timer
   import perf_timer_pkg::*;
#(
   parameter int unsigned TS_W      = c_TS_W,
   parameter int unsigned NUM_STAGE = c_NUM_STAGE,
   parameter int unsigned BASE_DIV  = c_BASE_DIV,
   parameter int unsigned RATIO     = c_RATIO,
   parameter int unsigned ID_W      = c_ID_W
) (
   input  logic                            clk_1000m,
   input  logic                            perf_rst,
   input  logic                            en,
   input  logic                            clr,
   input  logic [sel_width(NUM_STAGE)-1:0] win_sel,
   input  logic                            snap_req,
   output logic [TS_W-1:0]                 ts,
   output logic                            ts_wrap,
   output logic [NUM_STAGE-1:0]            trig,
   output logic                            win_end,
   output logic [ID_W-1:0]                 win_id,
   output logic [TS_W-1:0]                 snap_ts,
   output logic                            snap_vld
);

   localparam int unsigned        c_SEL_W  = sel_width(NUM_STAGE);
   localparam logic [TS_W-1:0]    c_TS_ONE = TS_W'(1);
   localparam logic [ID_W-1:0]    c_ID_ONE = ID_W'(1);

   generate
      if (BASE_DIV < 1) begin : g_err_base
         $error("perf_window_timer: BASE_DIV must be at least 1");
      end
      if (RATIO < 2) begin : g_err_ratio
         $error("perf_window_timer: RATIO must be at least 2");
      end
      if (period(NUM_STAGE - 1, BASE_DIV, RATIO) < 0) begin : g_err_period
         $error("perf_window_timer: longest stage period does not fit in 63 bits");
      end
   endgenerate

   logic                 w_advance;
   logic [NUM_STAGE-1:0] w_carry;
   logic [c_SEL_W-1:0]   w_sel_next;
   logic                 w_win_end;

   logic [TS_W-1:0]      r_ts;
   logic                 r_wrap;
   logic [NUM_STAGE-1:0] r_trig;
   logic [c_SEL_W-1:0]   r_sel;
   logic [ID_W-1:0]      r_win_id;
   logic [TS_W-1:0]      r_snap_ts;
   logic                 r_snap_vld;

   assign w_advance  = en & ~clr;
   assign w_sel_next = c_SEL_W'(sel_clamp(32'(win_sel), NUM_STAGE));
   assign w_win_end  = r_trig[r_sel];

   // Stage 0 divides the advance stream; each later stage divides its predecessor's carry.
   generate
      for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
         if (k == 0) begin : g_base
            perf_prescale_stage #(.N(BASE_DIV)) u_presc (
               .clk     (clk_1000m),
               .rst     (perf_rst),
               .i_clr   (clr),
               .i_inc   (w_advance),
               .o_carry (w_carry[k])
            );
         end else begin : g_cascade
            perf_prescale_stage #(.N(RATIO)) u_presc (
               .clk     (clk_1000m),
               .rst     (perf_rst),
               .i_clr   (clr),
               .i_inc   (w_carry[k-1]),
               .o_carry (w_carry[k])
            );
         end
      end
   endgenerate

   always_ff @(posedge clk_1000m) begin
      if (perf_rst) begin
         r_ts   <= '0;
         r_wrap <= 1'b0;
         r_trig <= '0;
      end else if (clr) begin
         r_ts   <= '0;
         r_wrap <= 1'b0;
         r_trig <= '0;
      end else begin
         r_trig <= w_carry;
         if (w_advance) begin
            r_ts <= r_ts + c_TS_ONE;
            if (r_ts == {TS_W{1'b1}}) begin
               r_wrap <= 1'b1;
            end
         end
      end
   end

   // The window selection is only re-sampled when a window closes, so changes land on the next one.
   always_ff @(posedge clk_1000m) begin
      if (perf_rst) begin
         r_sel    <= '0;
         r_win_id <= '0;
      end else if (clr) begin
         r_sel    <= w_sel_next;
         r_win_id <= '0;
      end else if (w_win_end) begin
         r_sel    <= w_sel_next;
         r_win_id <= r_win_id + c_ID_ONE;
      end
   end

   always_ff @(posedge clk_1000m) begin
      if (perf_rst) begin
         r_snap_ts  <= '0;
         r_snap_vld <= 1'b0;
      end else begin
         r_snap_vld <= snap_req;
         if (snap_req) begin
            r_snap_ts <= r_ts;
         end
      end
   end

   assign ts       = r_ts;
   assign ts_wrap  = r_wrap;
   assign trig     = r_trig;
   assign win_end  = w_win_end;
   assign win_id   = r_win_id;
   assign snap_ts  = r_snap_ts;
   assign snap_vld = r_snap_vld;

endmodule
`default_nettype wire

// File: tb/tb_perf_window_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_perf_window_timer : self-checking bench for perf_window_timer (three configurations)
// Rev 1.0
// ============================================================================
module tb_perf_window_timer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Instance A: default parameters
   logic        rst_a, en_a, clr_a, snap_a;
   logic [3:0]  ws_a;
   logic [47:0] ts_a, snap_ts_a;
   logic        wrap_a, we_a, snap_vld_a;
   logic [8:0]  trig_a;
   logic [15:0] id_a;

   // Instance B: BASE_DIV=2, RATIO=3, NUM_STAGE=3
   logic        rst_b, en_b, clr_b, snap_b;
   logic [1:0]  ws_b;
   logic [47:0] ts_b, snap_ts_b;
   logic        wrap_b, we_b, snap_vld_b;
   logic [2:0]  trig_b;
   logic [15:0] id_b;

   // Instance C: TS_W=8
   logic        rst_c, en_c, clr_c, snap_c;
   logic [3:0]  ws_c;
   logic [7:0]  ts_c, snap_ts_c;
   logic        wrap_c, we_c, snap_vld_c;
   logic [8:0]  trig_c;
   logic [15:0] id_c;

   perf_window_timer dut_a (
      .clk_1000m(clk), .perf_rst(rst_a), .en(en_a), .clr(clr_a), .win_sel(ws_a),
      .snap_req(snap_a), .ts(ts_a), .ts_wrap(wrap_a), .trig(trig_a), .win_end(we_a),
      .win_id(id_a), .snap_ts(snap_ts_a), .snap_vld(snap_vld_a)
   );

   perf_window_timer #(.BASE_DIV(2), .RATIO(3), .NUM_STAGE(3)) dut_b (
      .clk_1000m(clk), .perf_rst(rst_b), .en(en_b), .clr(clr_b), .win_sel(ws_b),
      .snap_req(snap_b), .ts(ts_b), .ts_wrap(wrap_b), .trig(trig_b), .win_end(we_b),
      .win_id(id_b), .snap_ts(snap_ts_b), .snap_vld(snap_vld_b)
   );

   perf_window_timer #(.TS_W(8)) dut_c (
      .clk_1000m(clk), .perf_rst(rst_c), .en(en_c), .clr(clr_c), .win_sel(ws_c),
      .snap_req(snap_c), .ts(ts_c), .ts_wrap(wrap_c), .trig(trig_c), .win_end(we_c),
      .win_id(id_c), .snap_ts(snap_ts_c), .snap_vld(snap_vld_c)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // ---------------- reference model + scoreboard for instance A ----------------
   typedef struct {
      logic [47:0] ts;
      logic        wrap;
      logic [8:0]  trig;
      logic        win_end;
      logic [15:0] win_id;
      logic [47:0] snap_ts;
      logic        snap_vld;
   } obs_t;

   obs_t        sb_q[$];
   longint      per[9];
   logic [47:0] m_ts = '0;
   logic        m_wrap = 1'b0;
   logic [8:0]  m_trig = '0;
   logic [3:0]  m_sel = '0;
   logic [15:0] m_id = '0;
   logic [47:0] m_snap_ts = '0;
   logic        m_snap_vld = 1'b0;
   longint      m_adv = 0;

   function automatic logic [3:0] clamp9(input logic [3:0] s);
      return (s > 4'd8) ? 4'd8 : s;
   endfunction

   task automatic sb_push();
      obs_t e;
      logic cur_we;
      cur_we = m_trig[m_sel];
      if (rst_a) begin
         m_ts = '0; m_wrap = 1'b0; m_trig = '0; m_sel = '0; m_id = '0;
         m_snap_ts = '0; m_snap_vld = 1'b0; m_adv = 0;
      end else begin
         if (snap_a) m_snap_ts = m_ts;
         m_snap_vld = snap_a;
         if (clr_a) begin
            m_ts = '0; m_wrap = 1'b0; m_adv = 0; m_trig = '0; m_id = '0;
            m_sel = clamp9(ws_a);
         end else begin
            if (cur_we) begin
               m_id  = m_id + 16'd1;
               m_sel = clamp9(ws_a);
            end
            m_trig = '0;
            if (en_a) begin
               if (m_ts == {48{1'b1}}) m_wrap = 1'b1;
               m_ts  = m_ts + 48'd1;
               m_adv = m_adv + 1;
               for (int k = 0; k < 9; k++) m_trig[k] = ((m_adv % per[k]) == 0);
            end
         end
      end
      e.ts = m_ts; e.wrap = m_wrap; e.trig = m_trig; e.win_end = m_trig[m_sel];
      e.win_id = m_id; e.snap_ts = m_snap_ts; e.snap_vld = m_snap_vld;
      sb_q.push_back(e);
   endtask

   task automatic sb_check();
      obs_t e;
      n_checks++;
      if (sb_q.size() == 0) begin
         n_errors++;
         $display("FAIL sb_A: no expected entry queued at %0t", $time);
         return;
      end
      e = sb_q.pop_front();
      if (ts_a !== e.ts || wrap_a !== e.wrap || trig_a !== e.trig || we_a !== e.win_end ||
          id_a !== e.win_id || snap_ts_a !== e.snap_ts || snap_vld_a !== e.snap_vld) begin
         n_errors++;
         $display("FAIL sb_A t=%0t: got ts=%0d wrap=%b trig=%h we=%b id=%0d sts=%0d sv=%b, expected ts=%0d wrap=%b trig=%h we=%b id=%0d sts=%0d sv=%b",
                  $time, ts_a, wrap_a, trig_a, we_a, id_a, snap_ts_a, snap_vld_a,
                  e.ts, e.wrap, e.trig, e.win_end, e.win_id, e.snap_ts, e.snap_vld);
      end
   endtask

   task automatic step();
      sb_push();
      @(posedge clk);
      #1;
      sb_check();
   endtask

   // ---------------- table of segments for instance A ----------------
   typedef struct {
      logic        en;
      logic        clr;
      logic [3:0]  ws;
      logic        snap;
      int          n;
      logic [47:0] ts;
      logic [15:0] id;
      logic [8:0]  trig;
   } vec_t;

   vec_t        vt[9];
   logic [7:0]  snap_q[$];
   int          f0, f1, f2, nwe;
   logic        exp_we;
   logic [2:0]  e3;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      per[0] = 10;
      for (int k = 1; k < 9; k++) per[k] = per[k-1] * 10;

      rst_a = 1'b1; en_a = 1'b0; clr_a = 1'b0; snap_a = 1'b0; ws_a = 4'd0;
      rst_b = 1'b1; en_b = 1'b0; clr_b = 1'b0; snap_b = 1'b0; ws_b = 2'd0;
      rst_c = 1'b1; en_c = 1'b0; clr_c = 1'b0; snap_c = 1'b0; ws_c = 4'd0;
      repeat (3) step();
      chk("rst_ts_a", ts_a, 0);
      chk("rst_trig_a", trig_a, 0);
      chk("rst_id_a", id_a, 0);
      chk("rst_snapvld_a", snap_vld_a, 0);
      chk("rst_ts_b", ts_b, 0);
      chk("rst_ts_c", ts_c, 0);

      // Cascade start-up and pulse widths
      rst_a = 1'b0; en_a = 1'b1;
      f0 = -1; f1 = -1; f2 = -1;
      for (int i = 1; i <= 1000; i++) begin
         step();
         if (trig_a[0] === 1'b1 && f0 < 0) f0 = i;
         if (trig_a[1] === 1'b1 && f1 < 0) f1 = i;
         if (trig_a[2] === 1'b1 && f2 < 0) f2 = i;
         if (i == 11)   chk("t1_trig_at11", trig_a, 9'h000);
         if (i == 100)  chk("t1_trig_at100", trig_a, 9'h003);
         if (i == 101)  chk("t1_trig_at101", trig_a, 9'h000);
         if (i == 1000) chk("t1_trig_at1000", trig_a, 9'h007);
      end
      chk("t1_first_trig0", f0, 10);
      chk("t1_first_trig1", f1, 100);
      chk("t1_first_trig2", f2, 1000);

      // Window selection changes only on the following window
      ws_a = 4'd1; clr_a = 1'b1;
      step();
      clr_a = 1'b0;
      nwe = 0;
      for (int i = 1; i <= 220; i++) begin
         step();
         exp_we = (i == 100) || (i == 200) || (i == 210) || (i == 220);
         chk("t3_win_end", we_a, exp_we);
         if (exp_we) begin
            chk("t3_win_id", id_a, nwe);
            nwe++;
         end
         if (i == 150) ws_a = 4'd0;
      end

      // Segment table: clear, pause, snapshot, clamp
      vt[0] = '{1'b1, 1'b1, 4'd0,  1'b0, 1,   48'd0,   16'd0, 9'h000};
      vt[1] = '{1'b1, 1'b0, 4'd0,  1'b0, 57,  48'd57,  16'd5, 9'h000};
      vt[2] = '{1'b1, 1'b1, 4'd0,  1'b0, 1,   48'd0,   16'd0, 9'h000};
      vt[3] = '{1'b1, 1'b0, 4'd0,  1'b0, 10,  48'd10,  16'd0, 9'h001};
      vt[4] = '{1'b0, 1'b0, 4'd0,  1'b0, 4,   48'd10,  16'd1, 9'h000};
      vt[5] = '{1'b1, 1'b0, 4'd0,  1'b1, 1,   48'd11,  16'd1, 9'h000};
      vt[6] = '{1'b1, 1'b1, 4'd15, 1'b0, 1,   48'd0,   16'd0, 9'h000};
      vt[7] = '{1'b1, 1'b0, 4'd0,  1'b0, 100, 48'd100, 16'd0, 9'h003};
      vt[8] = '{1'b1, 1'b0, 4'd0,  1'b0, 35,  48'd135, 16'd0, 9'h000};
      for (int v = 0; v < 9; v++) begin
         en_a = vt[v].en; clr_a = vt[v].clr; ws_a = vt[v].ws; snap_a = vt[v].snap;
         repeat (vt[v].n) step();
         chk($sformatf("vec%0d_ts", v), ts_a, vt[v].ts);
         chk($sformatf("vec%0d_id", v), id_a, vt[v].id);
         chk($sformatf("vec%0d_trig", v), trig_a, vt[v].trig);
      end
      clr_a = 1'b0; snap_a = 1'b0;

      // Reset mid-window
      rst_a = 1'b1;
      step();
      chk("t6_ts", ts_a, 0);
      chk("t6_wrap", wrap_a, 0);
      chk("t6_trig", trig_a, 0);
      chk("t6_we", we_a, 0);
      chk("t6_id", id_a, 0);
      chk("t6_snap_ts", snap_ts_a, 0);
      chk("t6_snap_vld", snap_vld_a, 0);
      rst_a = 1'b0;
      repeat (10) step();
      chk("t6_ts_after", ts_a, 10);
      chk("t6_trig_after", trig_a, 9'h001);
      chk("t6_we_after", we_a, 1);
      en_a = 1'b0;

      // Instance B: pause and resume, clamped window selection
      rst_b = 1'b0; clr_b = 1'b1; ws_b = 2'd3;
      step();
      chk("t2_ts_clr", ts_b, 0);
      clr_b = 1'b0; en_b = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         chk("t2_ts_run", ts_b, i);
         chk("t2_trig_run", trig_b, (i % 2 == 0) ? 3'b001 : 3'b000);
      end
      en_b = 1'b0;
      repeat (4) begin
         step();
         chk("t2_ts_hold", ts_b, 5);
         chk("t2_trig_hold", trig_b, 3'b000);
      end
      en_b = 1'b1;
      for (int i = 6; i <= 18; i++) begin
         step();
         e3 = {(i % 18 == 0), (i % 6 == 0), (i % 2 == 0)};
         chk("t2_ts_resume", ts_b, i);
         chk("t2_trig_resume", trig_b, e3);
         chk("t2_win_end", we_b, (i == 18));
         chk("t2_win_id", id_b, 0);
      end
      step();
      chk("t2_win_id_after", id_b, 1);
      en_b = 1'b0;

      // Instance C: 8-bit timestamp wrap and snapshots
      rst_c = 1'b0; en_c = 1'b1;
      for (int i = 1; i <= 286; i++) begin
         snap_c = ((i - 1) == 77);
         if (snap_c) snap_q.push_back(8'((i - 1) % 256));
         step();
         chk("t5_ts", ts_c, (i % 256));
         chk("t5_wrap", wrap_c, (i >= 256));
         chk("t5_trig0", trig_c[0], (i % 10 == 0));
         chk("t5_snap_vld", snap_vld_c, ((i - 1) == 77));
         if (snap_vld_c === 1'b1) begin
            if (snap_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL t5_snap_unexpected: got snap_ts=%0d, expected no snapshot", snap_ts_c);
            end else begin
               chk("t5_snap_ts", snap_ts_c, snap_q.pop_front());
            end
         end
      end
      snap_c = 1'b1; clr_c = 1'b1;
      snap_q.push_back(8'd30);
      step();
      chk("t5_clr_ts", ts_c, 0);
      chk("t5_clr_wrap", wrap_c, 0);
      chk("t5_clr_snap_vld", snap_vld_c, 1);
      if (snap_q.size() == 0) begin
         n_checks++; n_errors++;
         $display("FAIL t5_snap_queue: got empty queue, expected pending snapshot");
      end else begin
         chk("t5_clr_snap_ts", snap_ts_c, snap_q.pop_front());
      end
      snap_c = 1'b0; clr_c = 1'b0;
      step();
      chk("t5_snap_vld_drop", snap_vld_c, 0);
      chk("t5_snap_hold", snap_ts_c, 30);
      chk("t5_snap_queue_empty", snap_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
